imem_loader: RTL

Boot-time program loader that writes the instruction memory from a byte stream: it packs four incoming bytes into one 32-bit instruction word and issues one write per word to the writable instruction RAM's write port. It sits between the host byte source (UART receiver or testbench) and the instruction RAM. It holds the CPU in reset until the requested number of words has been written.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_if.sv | 29 ++
 rtl/imem_byte_packer.sv | 44 ++++
 rtl/imem_loader.sv | 96 +++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared instruction-RAM geometry and loader state encoding.
package imem_pkg;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 2048;
    localparam int unsigned CNT_W  = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } ldr_state_t;

    // Requested word counts beyond the RAM depth are clamped to the depth.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] wc);
        logic [CNT_W-1:0] depth_cnt;
        depth_cnt = CNT_W'(DEPTH);
        return (wc > depth_cnt) ? depth_cnt : wc;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, RAM write port and status out, for the boot loader.
interface imem_loader_if;
    import imem_pkg::*;

    logic              start;
    logic [CNT_W-1:0]  word_count;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic              cpu_hold;

    // Host / byte source side.
    modport master (
        output start, word_count, byte_valid, byte_data,
        input  byte_ready, we, waddr, wdata, busy, done, cpu_hold
    );

    // Loader side.
    modport slave (
        input  start, word_count, byte_valid, byte_data,
        output byte_ready, we, waddr, wdata, busy, done, cpu_hold
    );

endinterface

// File: rtl/imem_byte_packer.sv
// Packs four accepted bytes, first byte most significant, into one word.
module imem_byte_packer
    import imem_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              accept_i,
    input  logic              clear_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic              last_byte_o
);

    logic [1:0]        bcnt_q, bcnt_d;
    logic [DATA_W-1:0] word_q, word_d;

    // Shift in accepted bytes; after four shifts byte 0 sits in bits [31:24].
    always_comb begin
        bcnt_d = bcnt_q;
        word_d = word_q;
        if (clear_i) begin
            bcnt_d = 2'd0;
            word_d = '0;
        end else if (accept_i) begin
            bcnt_d = bcnt_q + 2'd1;
            word_d = {word_q[DATA_W-9:0], byte_i};
        end
    end

    // Counter and shift register, synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bcnt_q <= 2'd0;
            word_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
            word_q <= word_d;
        end
    end

    assign word_o      = word_q;
    assign last_byte_o = (bcnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into instruction RAM words, holds the CPU until done.
module imem_loader
    import imem_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    imem_loader_if.slave bus
);

    ldr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              start_ok;
    logic              accept;
    logic              last_byte;
    logic              last_word;
    logic [DATA_W-1:0] word;

    assign start_ok  = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
    assign accept    = (state_q == LOAD) && bus.byte_valid;
    assign last_word = ({1'b0, idx_q} == (n_q - CNT_W'(1)));

    imem_byte_packer u_packer (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .accept_i    (accept),
        .clear_i     (start_ok),
        .byte_i      (bus.byte_data),
        .word_o      (word),
        .last_byte_o (last_byte)
    );

    // Next-state logic for the load sequence.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    n_d     = clamp_count(bus.word_count);
                    idx_d   = '0;
                    state_d = (n_d == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (accept && last_byte) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, word index, count and held write-port values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            if (state_q == WRITE) begin
                waddr_q <= idx_q;
                wdata_q <= word;
            end
        end
    end

    // Outputs decoded from registered state only; address/data hold after a write.
    always_comb begin
        bus.byte_ready = (state_q == LOAD);
        bus.we         = (state_q == WRITE);
        bus.waddr      = (state_q == WRITE) ? idx_q : waddr_q;
        bus.wdata      = (state_q == WRITE) ? word : wdata_q;
        bus.busy       = (state_q == LOAD) || (state_q == WRITE);
        bus.done       = (state_q == DONE);
        bus.cpu_hold   = (state_q != DONE);
    end

endmodule
